mm_final_sub: RTL and testbench

- Downstream stage of the word-serial Montgomery multiplier (mm_iddmm_top).
- Consumes the N-word result stream (K bits per word, least-significant word first) and applies the final conditional subtraction: out = (R >= M) ? R - M : R.
- Buffers the whole operand, because the decision is known only after the last word's borrow.
- Re-emits the reduced result as an N-word stream in the same word order, so later stages (exponentiation control, result capture) always see a fully reduced value below M.

---
 rtl/mm_final_sub_if.sv | 29 ++
 rtl/mm_final_sub.sv | 160 ++++++++++++++++
 tb/tb_mm_final_sub.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mm_final_sub_if.sv
// rtl/mm_final_sub_if.sv - modulus load, result-word input and reduced-word output bundle of the final subtraction stage
interface mm_final_sub_if #(
  parameter int K  = 128,
  parameter int AW = 5
);
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [K-1:0]  m_data;
  logic          in_start;
  logic          in_valid;
  logic [K-1:0]  in_data;
  logic          out_valid;
  logic [K-1:0]  out_data;
  logic          out_last;
  logic          busy;
  logic          err;

  // Producer side: modulus loader and upstream multiplier; also consumes the reduced stream.
  modport master (
    output m_wr, m_addr, m_data, in_start, in_valid, in_data,
    input  out_valid, out_data, out_last, busy, err
  );

  // The final-subtraction stage itself.
  modport slave (
    input  m_wr, m_addr, m_data, in_start, in_valid, in_data,
    output out_valid, out_data, out_last, busy, err
  );
endinterface

// File: rtl/mm_final_sub.sv
// rtl/mm_final_sub.sv - buffers an N-word Montgomery result and re-emits it conditionally reduced by M
module mm_final_sub #(
  parameter int K  = 128,
  parameter int N  = 32,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  mm_final_sub_if.slave bus
);

  localparam logic [1:0]    S_IDLE    = 2'd0;
  localparam logic [1:0]    S_COLLECT = 2'd1;
  localparam logic [1:0]    S_EMIT    = 2'd2;
  localparam logic [AW-1:0] LAST_IDX  = AW'(N - 1);

  // Modulus, raw result and R-M difference; none of these are reset.
  logic [K-1:0] m_mem [N];
  logic [K-1:0] r_mem [N];
  logic [K-1:0] d_mem [N];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          borrow_q, borrow_d;
  logic          sel_q, sel_d;
  logic          issue_done_q, issue_done_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_last_q, rd_last_d;
  logic [K-1:0]  rd_data_q, rd_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [K-1:0]  out_data_q, out_data_d;
  logic          err_q, err_d;

  logic          restart;
  logic [AW-1:0] eff_idx;
  logic          eff_borrow;
  logic [K:0]    diff;
  logic          buf_we;
  logic          m_we;

  // Next-state logic: word collection with running borrow, then an N-cycle
  // emission through a read stage and an output stage.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    borrow_d     = borrow_q;
    sel_d        = sel_q;
    issue_done_d = issue_done_q;
    err_d        = err_q;
    rd_vld_d     = 1'b0;
    rd_last_d    = 1'b0;
    rd_data_d    = '0;
    out_valid_d  = rd_vld_q;
    out_last_d   = rd_last_q;
    out_data_d   = rd_vld_q ? rd_data_q : '0;
    buf_we       = 1'b0;
    m_we         = 1'b0;

    // A word arriving in IDLE, or together with in_start, is word 0 with no borrow in.
    restart    = (state_q == S_IDLE) || bus.in_start;
    eff_idx    = restart ? '0 : idx_q;
    eff_borrow = restart ? 1'b0 : borrow_q;
    diff       = {1'b0, bus.in_data} - {1'b0, m_mem[eff_idx]} - {{K{1'b0}}, eff_borrow};

    if (bus.m_wr) begin
      if (state_q == S_IDLE) m_we = 1'b1;
      else                   err_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (bus.in_valid) begin
          buf_we   = 1'b1;
          borrow_d = diff[K];
          if (eff_idx == LAST_IDX) begin
            // No borrow out of the top word means R >= M, so emit the difference.
            sel_d        = ~diff[K];
            state_d      = S_EMIT;
            idx_d        = '0;
            issue_done_d = 1'b0;
          end else begin
            idx_d   = eff_idx + AW'(1);
            state_d = S_COLLECT;
          end
        end else if (bus.in_start) begin
          idx_d    = '0;
          borrow_d = 1'b0;
          state_d  = S_COLLECT;
        end
      end
      S_EMIT: begin
        if (bus.in_valid || bus.in_start) err_d = 1'b1;
        if (!issue_done_q) begin
          rd_vld_d  = 1'b1;
          rd_last_d = (idx_q == LAST_IDX);
          rd_data_d = sel_q ? d_mem[idx_q] : r_mem[idx_q];
          idx_d     = idx_q + AW'(1);
          if (idx_q == LAST_IDX) issue_done_d = 1'b1;
        end
        // Leave EMIT at the end of the out_last cycle.
        if (out_last_q) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Control and output registers, abandoned immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      borrow_q     <= 1'b0;
      sel_q        <= 1'b0;
      issue_done_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_data_q    <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      borrow_q     <= borrow_d;
      sel_q        <= sel_d;
      issue_done_q <= issue_done_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
      rd_data_q    <= rd_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      err_q        <= err_d;
    end
  end

  // Word storage writes: modulus in IDLE, result and difference per accepted word.
  always_ff @(posedge clk) begin
    if (m_we) m_mem[bus.m_addr] <= bus.m_data;
    if (buf_we) begin
      r_mem[eff_idx] <= bus.in_data;
      d_mem[eff_idx] <= diff[K-1:0];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mm_final_sub.sv
// tb/tb_mm_final_sub.sv - self-checking bench for mm_final_sub against a whole-operand arithmetic model
module tb_mm_final_sub;
  localparam int K  = 128;
  localparam int N  = 32;
  localparam int AW = $clog2(N);
  localparam int W  = K * N;

  typedef struct {
    logic [W-1:0] m;
    logic [W-1:0] r;
    logic [W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mm_final_sub_if #(.K(K), .AW(AW)) bus ();

  mm_final_sub #(.K(K), .N(N), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input bit ok, input string nm, input logic [K-1:0] act, input logic [K-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] r, input logic [W-1:0] m);
    return (r >= m) ? r - m : r;
  endfunction

  function automatic logic [K-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] rnd_wide();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*K +: K] = rnd_word();
    return v;
  endfunction

  task automatic drive(input bit v, input bit s, input logic [K-1:0] d);
    @(posedge clk); #1;
    bus.in_valid = v;
    bus.in_start = s;
    bus.in_data  = d;
  endtask

  task automatic load_m(input logic [W-1:0] m);
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      bus.m_wr   = 1'b1;
      bus.m_addr = AW'(i);
      bus.m_data = m[i*K +: K];
    end
    @(posedge clk); #1;
    bus.m_wr = 1'b0;
  endtask

  // Streams r (optionally after an aborted partial collection), then checks the emitted words.
  task automatic run_op(input logic [W-1:0] r, input logic [W-1:0] exp, input bit use_start,
                        input bit gaps, input int pre_words, input int inject_at,
                        input int reset_at, input string nm);
    int nwait;
    for (int j = 0; j < pre_words; j++) drive(1'b1, j == 0, rnd_word());
    for (int i = 0; i < N; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) repeat ($urandom_range(1, 3)) drive(1'b0, 1'b0, '0);
      drive(1'b1, (i == 0) && use_start, r[i*K +: K]);
    end
    drive(1'b0, 1'b0, '0);
    nwait = 0;
    do begin
      @(negedge clk);
      nwait++;
    end while (!bus.out_valid && nwait < 10);
    if (!bus.out_valid) begin
      chk(1'b0, {nm, " out_valid timeout"}, K'(nwait), K'(3));
      return;
    end
    chk(nwait == 3, {nm, " first-word latency"}, K'(nwait), K'(3));
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      if (i == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk(bus.out_valid === 1'b0 && bus.busy === 1'b0 && bus.out_last === 1'b0,
            {nm, " async reset in EMIT"}, K'({bus.out_valid, bus.busy, bus.out_last}), K'(0));
        return;
      end
      if (bus.out_valid !== 1'b1) begin
        chk(1'b0, $sformatf("%s out_valid gap word%0d", nm, i), K'(bus.out_valid), K'(1));
        return;
      end
      chk(bus.out_data === exp[i*K +: K], $sformatf("%s data word%0d", nm, i), bus.out_data, exp[i*K +: K]);
      chk(bus.out_last === (i == N - 1), $sformatf("%s out_last word%0d", nm, i), K'(bus.out_last), K'(i == N - 1));
      if (i == inject_at) begin
        bus.in_valid = 1'b1;
        bus.in_data  = rnd_word();
        bus.m_wr     = 1'b1;
        bus.m_addr   = '0;
        bus.m_data   = rnd_word();
      end else begin
        bus.in_valid = 1'b0;
        bus.m_wr     = 1'b0;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.m_wr     = 1'b0;
    chk(bus.out_valid === 1'b0 && bus.out_last === 1'b0 && bus.busy === 1'b0,
        {nm, " idle after last"}, K'({bus.out_valid, bus.out_last, bus.busy}), K'(0));
  endtask

  initial begin
    vec_t         tbl[6];
    logic [W-1:0] m, r;

    bus.m_wr = 1'b0; bus.m_addr = '0; bus.m_data = '0;
    bus.in_start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;

    tbl[0].m = W'(5);                        tbl[0].r = W'(3);                    tbl[0].exp = W'(3);
    tbl[1].m = W'(5);                        tbl[1].r = W'(5);                    tbl[1].exp = W'(0);
    tbl[2].m = W'(5);                        tbl[2].r = W'(4);                    tbl[2].exp = W'(4);
    tbl[3].m = W'(1) << K;                   tbl[3].r = (W'(1) << K) + W'(7);     tbl[3].exp = W'(7);
    tbl[4].m = ({W{1'b1}} >> 1) - W'(1);     tbl[4].r = tbl[4].m + W'('h10);      tbl[4].exp = W'('h10);
    tbl[5].m = ({W{1'b1}} >> 1) - W'(1);     tbl[5].r = tbl[5].m - W'(1);         tbl[5].exp = tbl[5].m - W'(1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk(bus.out_valid === 1'b0, "reset out_valid", K'(bus.out_valid), K'(0));
    chk(bus.out_data === '0, "reset out_data", bus.out_data, '0);
    chk(bus.out_last === 1'b0, "reset out_last", K'(bus.out_last), K'(0));
    chk(bus.busy === 1'b0, "reset busy", K'(bus.busy), K'(0));
    chk(bus.err === 1'b0, "reset err", K'(bus.err), K'(0));

    for (int t = 0; t < 6; t++) begin
      load_m(tbl[t].m);
      run_op(tbl[t].r, tbl[t].exp, 1'b1, 1'b0, 0, -1, -1, $sformatf("vec%0d", t));
    end
    chk(bus.err === 1'b0, "err clear after clean ops", K'(bus.err), K'(0));

    // Abort of a partial collection by in_start, with gaps in the word stream.
    run_op(tbl[5].m + W'(9), W'(9), 1'b1, 1'b1, 10, -1, -1, "abort");
    chk(bus.err === 1'b0, "err after abort", K'(bus.err), K'(0));

    // Protocol violations during EMIT must not disturb the emission or the modulus.
    load_m(W'(5));
    run_op(W'(3), W'(3), 1'b1, 1'b0, 0, 5, -1, "inject");
    chk(bus.err === 1'b1, "err set by inject", K'(bus.err), K'(1));
    run_op(W'(5), W'(0), 1'b0, 1'b0, 0, -1, -1, "post-inject");
    chk(bus.err === 1'b1, "err sticky", K'(bus.err), K'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk(bus.err === 1'b0, "err cleared by reset", K'(bus.err), K'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset at emission word 10, then a fresh operation with the retained modulus.
    run_op(W'(7), W'(2), 1'b1, 1'b0, 0, -1, 10, "reset-mid");
    @(posedge clk); #1 rst_n = 1'b1;
    run_op(W'(7), W'(2), 1'b1, 1'b1, 0, -1, -1, "after-reset");

    // Random operands; top bit of M set keeps R < 2M.
    for (int it = 0; it < 8; it++) begin
      m = rnd_wide();
      m[W-1] = 1'b1;
      case ($urandom_range(0, 2))
        0:       r = rnd_wide();
        1:       r = m + W'(rnd_word());
        default: r = m - W'($urandom_range(0, 3));
      endcase
      load_m(m);
      run_op(r, model(r, m), $urandom_range(0, 1) == 1, 1'b1, 0, -1, -1, $sformatf("rand%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
